mem_rd_check: RTL

MEM_RD_CHECK -- requirements
Module: mem_rd_check

---
 rtl/mem_rd_check.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_rd_check.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rd_check
//  Purpose  : Single-outstanding memory read engine with parity checking.
//             A request is turned into a one-cycle read strobe, the memory
//             word {parity, data[7:0]} is captured two clocks after accept,
//             returned with a parity-error flag, and odd-parity captures are
//             tallied in a saturating error counter.
//  Ports    : clk, rst (async, active-high)
//             req_valid/req_ready/req_addr      - read request handshake
//             mem_read/mem_address/mem_data_out - memory read port
//             rsp_valid/rsp_ready/rsp_data/rsp_perr - response handshake
//             err_clr/err_count                 - parity error counter
//  Revision : 1.0 - initial release
// ============================================================================
module mem_rd_check #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_addr,
    output logic             mem_read,
    output logic [15:0]      mem_address,
    input  logic [8:0]       mem_data_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_perr,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] C_ERR_ONE = ERR_W'(1);

    state_t           state_q, state_d;
    logic             mem_read_q, mem_read_d;
    logic [15:0]      addr_q, addr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_perr_q, rsp_perr_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic w_accept;
    logic w_parity_odd;
    logic w_capture;

    // req_ready has to follow rsp_ready in the same cycle so a response can
    // retire and a new request be taken on one edge; it is therefore decoded
    // from the state register rather than registered itself. Gating with rst
    // keeps the block from advertising readiness while held in reset.
    assign req_ready = !rst &&
                       ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));

    assign w_accept     = req_valid && req_ready;
    assign w_parity_odd = ^mem_data_out;
    assign w_capture    = (state_q == S_WAIT);

    always_comb begin
        state_d     = state_q;
        mem_read_d  = 1'b0;          // strobe defaults low: never held past ISSUE
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_perr_d  = rsp_perr_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    addr_d     = req_addr;
                    mem_read_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // memory samples read/address on this edge
                state_d = S_WAIT;
            end
            S_WAIT: begin
                rsp_data_d  = mem_data_out[7:0];
                rsp_perr_d  = w_parity_odd;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (w_accept) begin
                        // retire and re-issue on the same edge, no idle bubble
                        addr_d     = req_addr;
                        mem_read_d = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Error counter: clear dominates a coincident odd-parity capture.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (w_capture && w_parity_odd && (err_q != C_ERR_MAX)) begin
            err_d = err_q + C_ERR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            addr_q      <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_perr_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_perr_q  <= rsp_perr_d;
            err_q       <= err_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_address = addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_perr    = rsp_perr_q;
    assign err_count   = err_q;

endmodule
`default_nettype wire
